mmc_cap_sort_sel: RTL and testbench
===================================

# mmc_cap_sort_sel

Sequential capacitor-voltage sorter and submodule selector for one arm of the MMC. The block sorts N_SM submodule capacitor voltages with an odd-even transposition network and emits an insertion mask. With positive arm current, the mask selects the n_ins lowest voltages for charging. With negative arm current, it selects the n_ins highest voltages for discharging. It sits between the ADC sample aggregator and the gate-signal generator. It generalises the combinational selection logic to parametrised width and count, adds direction-dependent mode and clamping, and adds a start/done handshake.

## Interface
- N_SM, default 8: submodules per arm; must be ≥ 2.
- VW, default 12: capacitor voltage width, unsigned.
- CW, default $clog2(N_SM+1): width of n_ins.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset; the only clock/reset pair.
- start  in  1  request; sampled only in IDLE.
- v_flat  in  N_SM*VW  voltages; submodule k occupies bits [k*VW +: VW]. Captured with start.
- n_ins  in  CW  number of submodules to insert. Captured with start.
- i_pos  in  1  1 = arm current positive (charging); 0 = negative (discharging). Captured with start.
- busy  out  1  high while a sort is in progress.
- done  out  1  one-cycle pulse when ins_mask updates.
- ins_mask  out  N_SM  bit k = 1 means insert submodule k; held between done pulses.
- n_clamped  out  1  sticky per result; set when the captured n_ins > N_SM.

## Operation
- FSM states: IDLE → SORT → EMIT → IDLE.
- IDLE, start=1: capture the voltages into key[ ], load idx[k]=k, latch the direction, latch n_eff=min(n_ins,N_SM), set n_clamped, clear the phase counter, go to SORT.
- IDLE, start=0: hold all state.
- SORT: one transposition phase per cycle, for N_SM cycles.
  - Even phase: compare-exchange pairs (0,1),(2,3)…
  - Odd phase: compare-exchange pairs (1,2),(3,4)…
  - Exchange moves key and idx together.
- Exchange rule:
  - i_pos=1 (ascending): swap only when key[j] > key[j+1].
  - i_pos=0 (descending): swap only when key[j] < key[j+1].
  - Strict compare keeps the sort stable, so equal voltages are ordered by lower submodule index first.
- After phase N_SM-1, go to EMIT.
- EMIT: ins_mask[idx[r]] = 1 for ranks r < n_eff, all other bits 0. Pulse done, return to IDLE.
- start during SORT or EMIT is ignored; the request is not queued.
- Inputs may change after the capture edge with no effect on the result in progress.
- n_ins=0 gives an all-zero mask. n_ins ≥ N_SM gives an all-ones mask.

## Timing
- Reset values: state=IDLE; busy=0; done=0; ins_mask=0; n_clamped=0; phase counter=0.
- Let edge T be the edge that samples start=1 in IDLE.
  - busy rises after T.
  - Edges T+1 … T+N_SM perform the sort phases.
  - Edge T+N_SM+1 updates ins_mask, asserts done for exactly one cycle and drops busy.
- Latency from start sample to visible result: N_SM+1 cycles.
- Throughput: one result per N_SM+2 cycles. start may be held high during the done cycle and is accepted at the next edge.
- ins_mask and n_clamped change only on the done edge or on reset.
- Reset asserted mid-sort: the in-flight sort is aborted immediately. All outputs return to their reset values and no done is issued.
- The phase counter wraps only through the FSM exit; it never exceeds N_SM-1.

## Structure
- Package mmc_sort_pkg holds:
  - the state enum (IDLE, SORT, EMIT);
  - a constant function for clog2 with a minimum of 1;
  - the default N_SM and VW.
- Sub-module mmc_sort_cas: one parametrised compare-exchange cell.
  - Inputs: two (key, idx) pairs, direction bit, enable.
  - Outputs: the ordered pair.
  - Purely combinational; instantiated N_SM-1 times with per-phase enables from the top.
- All registers live in the top module.

## Test plan
- N_SM=4, VW=8; v={10,40,20,30} (sm0..sm3); n_ins=2; i_pos=1 → done 5 cycles after the start edge; ins_mask=4'b0101; n_clamped=0.
- Same voltages, i_pos=0, n_ins=1 → ins_mask=4'b0010.
- Ties: v={25,25,25,25}, n_ins=2, i_pos=1 → 4'b0011. Repeat with i_pos=0 → also 4'b0011, confirming stability.
- Bounds: n_ins=0 → 4'b0000. n_ins=5 → 4'b1111 with n_clamped=1.
- start pulsed during SORT, and v_flat changed after capture → exactly one done; mask matches the captured data only.
- rst_n asserted at cycle T+2 of a sort → busy, done and ins_mask go to 0 immediately. No done pulse. A fresh start after release completes normally.

Source files
------------

// File: rtl/mmc_cap_sort_sel_pkg.sv
// mmc_sort_pkg
// Shared types and constants for the MMC capacitor-voltage sorter.
//   state_t     : sorter FSM state encoding
//   clog2_min1  : ceil(log2(v)), never less than 1 (safe vector width)
//   N_SM_DEF    : default submodule count per arm
//   VW_DEF      : default capacitor voltage width
package mmc_sort_pkg;

    localparam int N_SM_DEF = 8;
    localparam int VW_DEF   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        EMIT = 2'd2
    } state_t;

    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mmc_cap_sort_sel_if.sv
// mmc_cap_sort_sel_if
// Request/result bundle between the ADC aggregator (master) and the sorter (slave).
//   start     : request, sampled by the sorter only when idle
//   v_flat    : N_SM voltages, submodule k at [k*VW +: VW]
//   n_ins     : number of submodules to insert
//   i_pos     : 1 = charging (pick lowest), 0 = discharging (pick highest)
//   busy      : sort in progress
//   done      : one-cycle pulse when ins_mask updates
//   ins_mask  : bit k = insert submodule k
//   n_clamped : requested n_ins exceeded N_SM for the current result
interface mmc_cap_sort_sel_if
    import mmc_sort_pkg::*;
#(
    parameter int N_SM = N_SM_DEF,
    parameter int VW   = VW_DEF,
    parameter int CW   = clog2_min1(N_SM + 1)
);
    logic                 start;
    logic [N_SM*VW-1:0]   v_flat;
    logic [CW-1:0]        n_ins;
    logic                 i_pos;
    logic                 busy;
    logic                 done;
    logic [N_SM-1:0]      ins_mask;
    logic                 n_clamped;

    modport master (
        output start, v_flat, n_ins, i_pos,
        input  busy, done, ins_mask, n_clamped
    );

    modport slave (
        input  start, v_flat, n_ins, i_pos,
        output busy, done, ins_mask, n_clamped
    );

endinterface

// File: rtl/mmc_cap_sort_sel_cas.sv
// mmc_sort_cas
// One compare-exchange cell of the odd-even transposition network.
// Purely combinational. When enabled and the pair is out of order for the
// requested direction, the (key, idx) pairs are swapped as a unit. The strict
// compare leaves equal keys in place, which keeps the sort stable.
//   en       : cell active in the current phase
//   asc      : 1 = ascending order, 0 = descending order
//   a_key/a_idx, b_key/b_idx : input pair (a is the lower position)
//   o0_key/o0_idx, o1_key/o1_idx : ordered output pair
module mmc_sort_cas #(
    parameter int VW = 12,
    parameter int IW = 3
) (
    input  logic          en,
    input  logic          asc,
    input  logic [VW-1:0] a_key,
    input  logic [IW-1:0] a_idx,
    input  logic [VW-1:0] b_key,
    input  logic [IW-1:0] b_idx,
    output logic [VW-1:0] o0_key,
    output logic [IW-1:0] o0_idx,
    output logic [VW-1:0] o1_key,
    output logic [IW-1:0] o1_idx
);

    logic swap;

    assign swap = en && (asc ? (a_key > b_key) : (a_key < b_key));

    assign o0_key = swap ? b_key : a_key;
    assign o0_idx = swap ? b_idx : a_idx;
    assign o1_key = swap ? a_key : b_key;
    assign o1_idx = swap ? a_idx : b_idx;

endmodule

// File: rtl/mmc_cap_sort_sel.sv
// mmc_cap_sort_sel
// Sequential capacitor-voltage sorter and submodule selector for one MMC arm.
// Captures N_SM voltages on start, runs N_SM odd-even transposition phases
// (one per cycle), then emits a mask of the n_ins lowest (charging) or
// highest (discharging) submodules.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mmc_cap_sort_sel_if (start/data in, busy/done/mask out)
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SORT  | one transposition phase per cycle, phase = 0 .. N_SM-1
// EMIT  | publish ins_mask / n_clamped, pulse done, return to IDLE
module mmc_cap_sort_sel
    import mmc_sort_pkg::*;
#(
    parameter int N_SM = N_SM_DEF,
    parameter int VW   = VW_DEF,
    parameter int CW   = clog2_min1(N_SM + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    mmc_cap_sort_sel_if.slave  bus
);

    localparam int IW = clog2_min1(N_SM);
    localparam int PW = clog2_min1(N_SM);

    state_t           state;
    logic [PW-1:0]    phase;
    logic             dir_asc;
    logic [CW-1:0]    n_eff;
    logic             clamp_q;
    logic             busy_q;
    logic             done_q;
    logic [N_SM-1:0]  mask_q;
    logic             n_clamped_q;

    logic [VW-1:0]    key    [N_SM];
    logic [IW-1:0]    idx    [N_SM];
    logic [VW-1:0]    key_nx [N_SM];
    logic [IW-1:0]    idx_nx [N_SM];

    logic [N_SM-2:0]  cas_en;
    logic [VW-1:0]    c0_key [N_SM-1];
    logic [IW-1:0]    c0_idx [N_SM-1];
    logic [VW-1:0]    c1_key [N_SM-1];
    logic [IW-1:0]    c1_idx [N_SM-1];

    logic [N_SM-1:0]  mask_nx;
    logic             over;

    // Even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
    always_comb begin
        cas_en = '0;
        for (int j = 0; j < N_SM - 1; j++) begin
            cas_en[j] = (phase[0] == 1'(j % 2));
        end
    end

    for (genvar j = 0; j < N_SM - 1; j++) begin : g_cas
        mmc_sort_cas #(
            .VW (VW),
            .IW (IW)
        ) u_cas (
            .en     (cas_en[j]),
            .asc    (dir_asc),
            .a_key  (key[j]),
            .a_idx  (idx[j]),
            .b_key  (key[j+1]),
            .b_idx  (idx[j+1]),
            .o0_key (c0_key[j]),
            .o0_idx (c0_idx[j]),
            .o1_key (c1_key[j]),
            .o1_idx (c1_idx[j])
        );
    end

    // Pairs within a phase are disjoint, so each slot is written by at most
    // one enabled cell.
    always_comb begin
        key_nx = key;
        idx_nx = idx;
        for (int j = 0; j < N_SM - 1; j++) begin
            if (cas_en[j]) begin
                key_nx[j]   = c0_key[j];
                idx_nx[j]   = c0_idx[j];
                key_nx[j+1] = c1_key[j];
                idx_nx[j+1] = c1_idx[j];
            end
        end
    end

    // Ranks below n_eff map back to their original submodule positions.
    always_comb begin
        mask_nx = '0;
        for (int r = 0; r < N_SM; r++) begin
            if (r < int'(n_eff)) begin
                mask_nx[idx[r]] = 1'b1;
            end
        end
    end

    assign over = (bus.n_ins > CW'(N_SM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            dir_asc     <= 1'b0;
            n_eff       <= '0;
            clamp_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mask_q      <= '0;
            n_clamped_q <= 1'b0;
            for (int k = 0; k < N_SM; k++) begin
                key[k] <= '0;
                idx[k] <= IW'(k);
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < N_SM; k++) begin
                            key[k] <= bus.v_flat[k*VW +: VW];
                            idx[k] <= IW'(k);
                        end
                        dir_asc <= bus.i_pos;
                        n_eff   <= over ? CW'(N_SM) : bus.n_ins;
                        clamp_q <= over;
                        phase   <= '0;
                        busy_q  <= 1'b1;
                        state   <= SORT;
                    end
                end
                SORT: begin
                    key <= key_nx;
                    idx <= idx_nx;
                    if (phase == PW'(N_SM - 1)) begin
                        phase <= '0;
                        state <= EMIT;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                EMIT: begin
                    mask_q      <= mask_nx;
                    n_clamped_q <= clamp_q;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ins_mask  = mask_q;
    assign bus.n_clamped = n_clamped_q;

endmodule

// File: tb/tb_mmc_cap_sort_sel.sv
// tb_mmc_cap_sort_sel
// Directed bench for mmc_cap_sort_sel with N_SM=4, VW=8.
module tb_mmc_cap_sort_sel;

    localparam int N  = 4;
    localparam int VW = 8;
    localparam int CW = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mmc_cap_sort_sel_if #(.N_SM(N), .VW(VW), .CW(CW)) bus ();

    mmc_cap_sort_sel #(.N_SM(N), .VW(VW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*VW-1:0] pack4(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Presents a request at the falling edge; returns 1 ns after capture edge T.
    task automatic kick(input logic [N*VW-1:0] v, input logic [CW-1:0] n, input logic pos);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.v_flat = v;
        bus.n_ins  = n;
        bus.i_pos  = pos;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after T until done is seen (sampled 1 ns after each edge).
    task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                cyc  = c;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.start  = 1'b0;
        bus.v_flat = '0;
        bus.n_ins  = '0;
        bus.i_pos  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.ins_mask !== 4'b0000) begin errors++; $display("FAIL reset_mask got %b want 0000", bus.ins_mask); end
        checks++; if (bus.n_clamped !== 1'b0) begin errors++; $display("FAIL reset_clamp got %b want 0", bus.n_clamped); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ascending();
        int cyc; bit seen;
        kick(pack4(8'd10, 8'd40, 8'd20, 8'd30), 3'd2, 1'b1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL asc_busy_rise got %b want 1", bus.busy); end
        wait_done(10, cyc, seen);
        checks++; if (!seen || cyc != 5) begin errors++; $display("FAIL asc_latency got seen=%0d cyc=%0d want cyc=5", seen, cyc); end
        checks++; if (bus.ins_mask !== 4'b0101) begin errors++; $display("FAIL asc_mask got %b want 0101", bus.ins_mask); end
        checks++; if (bus.n_clamped !== 1'b0) begin errors++; $display("FAIL asc_clamp got %b want 0", bus.n_clamped); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL asc_busy_fall got %b want 0", bus.busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL asc_done_pulse got %b want 0", bus.done); end
        checks++; if (bus.ins_mask !== 4'b0101) begin errors++; $display("FAIL asc_mask_hold got %b want 0101", bus.ins_mask); end
    endtask

    task automatic test_descending();
        int cyc; bit seen;
        kick(pack4(8'd10, 8'd40, 8'd20, 8'd30), 3'd1, 1'b0);
        wait_done(10, cyc, seen);
        checks++; if (!seen || bus.ins_mask !== 4'b0010) begin errors++; $display("FAIL desc_mask got seen=%0d mask=%b want 0010", seen, bus.ins_mask); end
    endtask

    task automatic test_ties();
        int cyc; bit seen;
        kick(pack4(8'd25, 8'd25, 8'd25, 8'd25), 3'd2, 1'b1);
        wait_done(10, cyc, seen);
        checks++; if (!seen || bus.ins_mask !== 4'b0011) begin errors++; $display("FAIL ties_asc got seen=%0d mask=%b want 0011", seen, bus.ins_mask); end
        kick(pack4(8'd25, 8'd25, 8'd25, 8'd25), 3'd2, 1'b0);
        wait_done(10, cyc, seen);
        checks++; if (!seen || bus.ins_mask !== 4'b0011) begin errors++; $display("FAIL ties_desc got seen=%0d mask=%b want 0011", seen, bus.ins_mask); end
    endtask

    task automatic test_bounds();
        int cyc; bit seen;
        kick(pack4(8'd10, 8'd40, 8'd20, 8'd30), 3'd0, 1'b1);
        wait_done(10, cyc, seen);
        checks++; if (!seen || bus.ins_mask !== 4'b0000) begin errors++; $display("FAIL n0_mask got seen=%0d mask=%b want 0000", seen, bus.ins_mask); end
        kick(pack4(8'd10, 8'd40, 8'd20, 8'd30), 3'd5, 1'b1);
        wait_done(10, cyc, seen);
        checks++; if (!seen || bus.ins_mask !== 4'b1111) begin errors++; $display("FAIL n5_mask got seen=%0d mask=%b want 1111", seen, bus.ins_mask); end
        checks++; if (bus.n_clamped !== 1'b1) begin errors++; $display("FAIL n5_clamp got %b want 1", bus.n_clamped); end
        kick(pack4(8'd10, 8'd40, 8'd20, 8'd30), 3'd4, 1'b0);
        // n_clamped from the previous result must hold until this done edge
        checks++; if (bus.n_clamped !== 1'b1) begin errors++; $display("FAIL clamp_hold got %b want 1", bus.n_clamped); end
        wait_done(10, cyc, seen);
        checks++; if (!seen || bus.ins_mask !== 4'b1111) begin errors++; $display("FAIL n4_mask got seen=%0d mask=%b want 1111", seen, bus.ins_mask); end
        checks++; if (bus.n_clamped !== 1'b0) begin errors++; $display("FAIL n4_clamp got %b want 0", bus.n_clamped); end
    endtask

    task automatic test_ignore_start();
        int dones;
        kick(pack4(8'd10, 8'd40, 8'd20, 8'd30), 3'd2, 1'b1);
        dones = 0;
        bus.v_flat = pack4(8'd90, 8'd1, 8'd1, 8'd90);
        bus.n_ins  = 3'd1;
        bus.i_pos  = 1'b0;
        @(posedge clk); #1;
        if (bus.done === 1'b1) dones++;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        if (bus.done === 1'b1) dones++;
        bus.start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        checks++; if (bus.ins_mask !== 4'b0101) begin errors++; $display("FAIL ignore_mask got %b want 0101", bus.ins_mask); end
    endtask

    task automatic test_reset_mid_sort();
        int cyc; bit seen; int dones;
        kick(pack4(8'd10, 8'd40, 8'd20, 8'd30), 3'd2, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
        checks++; if (bus.ins_mask !== 4'b0000) begin errors++; $display("FAIL midrst_mask got %b want 0000", bus.ins_mask); end
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
        kick(pack4(8'd10, 8'd40, 8'd20, 8'd30), 3'd3, 1'b0);
        wait_done(10, cyc, seen);
        checks++; if (!seen || cyc != 5 || bus.ins_mask !== 4'b1110) begin
            errors++; $display("FAIL midrst_fresh got seen=%0d cyc=%0d mask=%b want cyc=5 mask=1110", seen, cyc, bus.ins_mask);
        end
    endtask

    task automatic test_back_to_back();
        int cyc1, cyc2; bit seen1, seen2;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.v_flat = pack4(8'd10, 8'd40, 8'd20, 8'd30);
        bus.n_ins  = 3'd2;
        bus.i_pos  = 1'b1;
        @(posedge clk);
        #1;
        bus.v_flat = pack4(8'd5, 8'd6, 8'd7, 8'd8);
        bus.i_pos  = 1'b0;
        wait_done(10, cyc1, seen1);
        checks++; if (!seen1 || cyc1 != 5 || bus.ins_mask !== 4'b0101) begin
            errors++; $display("FAIL b2b_first got seen=%0d cyc=%0d mask=%b want cyc=5 mask=0101", seen1, cyc1, bus.ins_mask);
        end
        wait_done(10, cyc2, seen2);
        bus.start = 1'b0;
        checks++; if (!seen2 || cyc2 != 6 || bus.ins_mask !== 4'b1100) begin
            errors++; $display("FAIL b2b_second got seen=%0d gap=%0d mask=%b want gap=6 mask=1100", seen2, cyc2, bus.ins_mask);
        end
        repeat (8) @(posedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ascending();
        test_descending();
        test_ties();
        test_bounds();
        test_ignore_start();
        test_reset_mid_sort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
